// File: rtl/clk_switch_ctrl.sv
// Glitch-safe clock switch sequencer: gate the clock, wait for quiesce, flip the mux, settle, re-enable.
// Optional DRAIN timeout abort is built when CLK_SWITCH_TIMEOUT_EN is defined.
module clk_switch_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  input  logic req_sel_i,
  output logic req_ready_o,
  input  logic quiesced_i,
  output logic clk_en_o,
  output logic select_o,
  output logic clk_selected_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, SETTLE} state_t;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic       target_q, target_d;
  logic       select_q, select_d;
  logic       cur_sel_q, cur_sel_d;
  logic       clk_en_q, clk_en_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;

`ifdef CLK_SWITCH_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] timeout_cnt_q, timeout_cnt_d;
  logic        err_q, err_d;
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    // NOTE: every next-state value is defaulted to hold before the case, so no path leaves one unassigned (no latches).
    state_d      = state_q;
    target_d     = target_q;
    select_d     = select_q;
    cur_sel_d    = cur_sel_q;
    clk_en_d     = clk_en_q;
    settle_cnt_d = settle_cnt_q;
    done_d       = 1'b0;
`ifdef CLK_SWITCH_TIMEOUT_EN
    timeout_cnt_d = timeout_cnt_q;
    err_d         = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        clk_en_d = 1'b1;
        if (req_valid_i && ready_q) begin
          if (req_sel_i == cur_sel_q) begin
            done_d = 1'b1;
          end else begin
            target_d = req_sel_i;
            clk_en_d = 1'b0;
            state_d  = DRAIN;
`ifdef CLK_SWITCH_TIMEOUT_EN
            timeout_cnt_d = '0;
`endif
          end
        end
      end
      DRAIN: begin
        // quiesce wins over a timeout reached in the same cycle
        if (quiesced_i) begin
          select_d     = target_q;
          settle_cnt_d = SETTLE_INIT;
          state_d      = SETTLE;
`ifdef CLK_SWITCH_TIMEOUT_EN
        end else if (timeout_cnt_q == TIMEOUT_LAST) begin
          err_d    = 1'b1;
          clk_en_d = 1'b1;
          state_d  = IDLE;
        end else begin
          timeout_cnt_d = timeout_cnt_q + 16'd1;
`endif
        end
      end
      SETTLE: begin
        if (settle_cnt_q == '0) begin
          clk_en_d  = 1'b1;
          cur_sel_d = target_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      target_q     <= 1'b0;
      select_q     <= 1'b0;
      cur_sel_q    <= 1'b0;
      clk_en_q     <= 1'b1;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      select_q     <= select_d;
      cur_sel_q    <= cur_sel_d;
      clk_en_q     <= clk_en_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

`ifdef CLK_SWITCH_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout_cnt_q <= '0;
      err_q         <= 1'b0;
    end else begin
      timeout_cnt_q <= timeout_cnt_d;
      err_q         <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign req_ready_o    = ready_q;
  assign busy_o         = busy_q;
  assign clk_en_o       = clk_en_q;
  assign select_o       = select_q;
  assign clk_selected_o = cur_sel_q;
  assign done_o         = done_q;

endmodule
